// File: rtl/io_out_fifo_if.sv
// Bus-side and byte-stream signals of the memory-mapped output FIFO.
interface io_out_fifo_if;
    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    modport master (
        output en, rw, m_size, abus, dbus_in, tx_ready,
        input  tx_data, tx_valid, irq
    );

    modport slave (
        input  en, rw, m_size, abus, dbus_in, tx_ready,
        output tx_data, tx_valid, irq
    );
endinterface

// File: rtl/io_out_fifo.sv
// Memory-mapped word FIFO drained MSB-first as a valid/ready byte stream,
// with status/control registers and a drain-done interrupt.
module io_out_fifo #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] IOADDR = 32'h7000
) (
    input  logic         clock,
    input  logic         reset,
    io_out_fifo_if.slave bus,
    output logic [31:0]  dbus_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state_q, state_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          en_q, overflow, done, irq_en;
    logic [31:0]   shift_q;
    logic [1:0]    idx;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;

    logic        acc, wr_data, wr_ctl, rd_stat;
    logic        full, empty, push, pop;
    logic        load, adv, finish;
    logic [31:0] push_word, status;

    // An access is taken once, on the rising edge of en.
    assign acc     = bus.en & ~en_q;
    assign wr_data = acc & ~bus.rw & (bus.abus == IOADDR);
    assign wr_ctl  = acc & ~bus.rw & (bus.abus == IOADDR + 32'd8);
    assign rd_stat = bus.en & bus.rw & (bus.abus == IOADDR + 32'd4);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = load;
    assign push  = wr_data & (~full | pop);

    always_comb begin
        unique case (bus.m_size)
            2'b00: push_word = {24'h0, bus.dbus_in[7:0]};
            2'b01: push_word = {16'h0, bus.dbus_in[15:0]};
            2'b10: push_word = {8'h0, bus.dbus_in[23:0]};
            2'b11: push_word = bus.dbus_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (idx != 2'd3) begin
                        adv = 1'b1;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            irq_en     <= 1'b0;
            shift_q    <= '0;
            idx        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= bus.en;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (wr_data & full & ~pop) overflow <= 1'b1;

            if (load) begin
                shift_q    <= mem[rd_ptr];
                tx_data_q  <= mem[rd_ptr][31:24];
                idx        <= '0;
                tx_valid_q <= 1'b1;
            end else if (adv) begin
                shift_q   <= shift_q << 8;
                tx_data_q <= shift_q[23:16];
                idx       <= idx + 2'd1;
            end else if (finish) begin
                tx_valid_q <= 1'b0;
            end

            // New data or an explicit clear beats a same-cycle completion.
            if (finish)  done <= 1'b1;
            if (wr_data) done <= 1'b0;
            if (wr_ctl) begin
                irq_en <= bus.dbus_in[0];
                if (bus.dbus_in[1]) begin
                    overflow <= 1'b0;
                    done     <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    assign status = {16'h0, 8'(count), 4'h0, done, overflow, full, empty};
    assign dbus_out = rd_stat ? status : 'z;

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.irq      = done & irq_en;
endmodule
